// File: rtl/clb_cfg_pkg.sv
// Shared types and width helpers for the LUT slice configuration loader.
// Frame widths are derived here so every file agrees on them.
package clb_cfg_pkg;

    function automatic int cfg_width(input int mem_size);
        return 2 * mem_size + 1;
    endfunction

    function automatic int words_per_frame(input int cfg_w, input int word_w);
        return (cfg_w + word_w - 1) / word_w;
    endfunction

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        COMMIT,
        DONE
    } state_t;

endpackage

// File: rtl/cfg_frame_assembler.sv
// Shadow register that packs stream words into one slice frame.
// Bits of the last word above the frame width are dropped.
module cfg_frame_assembler
    import clb_cfg_pkg::*;
#(
    parameter int CFG_WIDTH  = 33,
    parameter int WORD_WIDTH = 8
) (
    input  logic                  cclk,
    input  logic                  reset,
    input  logic                  clr,
    input  logic                  wr,
    input  logic [WORD_WIDTH-1:0] word,
    output logic [CFG_WIDTH-1:0]  frame,
    output logic                  frame_full
);

    localparam int WPF  = words_per_frame(CFG_WIDTH, WORD_WIDTH);
    localparam int CW   = (WPF > 1) ? $clog2(WPF) : 1;
    localparam int WIDE = WPF * WORD_WIDTH;
    localparam logic [CW-1:0] LAST = CW'(WPF - 1);

    logic [CW-1:0]   word_cnt;
    logic [WIDE-1:0] wide;

    assign frame_full = (word_cnt == LAST);

    // Merge the incoming word into a padded copy of the frame
    always_comb begin
        wide = '0;
        wide[CFG_WIDTH-1:0] = frame;
        for (int k = 0; k < WPF; k++) begin
            if (word_cnt == CW'(k)) begin
                wide[k*WORD_WIDTH +: WORD_WIDTH] = word;
            end
        end
    end

    // Capture accepted words and step the word counter without wrapping
    always_ff @(posedge cclk) begin
        if (reset) begin
            frame    <= '0;
            word_cnt <= '0;
        end else begin
            if (wr) begin
                frame <= wide[CFG_WIDTH-1:0];
                if (!frame_full) begin
                    word_cnt <= word_cnt + 1'b1;
                end
            end
            if (clr) begin
                word_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/lut_cfg_loader.sv
// Streams configuration frames into a column of fracturable LUT slices,
// committing each frame with a one-hot cen pulse, slice 0 first.
module lut_cfg_loader
    import clb_cfg_pkg::*;
#(
    parameter int INPUTS     = 4,
    parameter int MEM_SIZE   = 2 ** INPUTS,
    parameter int CFG_WIDTH  = cfg_width(MEM_SIZE),
    parameter int WORD_WIDTH = 8,
    parameter int NUM_LUTS   = 4
) (
    input  logic                  cclk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic [WORD_WIDTH-1:0] cfg_word,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    output logic [CFG_WIDTH-1:0]  config_out,
    output logic [NUM_LUTS-1:0]   cen,
    output logic                  busy,
    output logic                  done
);

    localparam int LW = (NUM_LUTS > 1) ? $clog2(NUM_LUTS) : 1;
    localparam logic [LW-1:0] LAST_LUT = LW'(NUM_LUTS - 1);

    state_t        state;
    logic [LW-1:0] lut_idx;
    logic          xfer;
    logic          clr;
    logic          frame_full;

    assign xfer = cfg_valid && cfg_ready && !abort;
    assign clr  = (state == IDLE && start && !abort) || state == COMMIT;

    cfg_frame_assembler #(
        .CFG_WIDTH  (CFG_WIDTH),
        .WORD_WIDTH (WORD_WIDTH)
    ) u_asm (
        .cclk       (cclk),
        .reset      (reset),
        .clr        (clr),
        .wr         (xfer),
        .word       (cfg_word),
        .frame      (config_out),
        .frame_full (frame_full)
    );

    // Slice enable comes straight from the registered state and slice index
    always_comb begin
        cen = '0;
        if (state == COMMIT) begin
            cen[lut_idx] = 1'b1;
        end
    end

    // Load sequencer with registered handshake and status outputs
    always_ff @(posedge cclk) begin
        if (reset) begin
            state     <= IDLE;
            cfg_ready <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            lut_idx   <= '0;
        end else if (abort) begin
            state     <= IDLE;
            cfg_ready <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state     <= RECV;
                        cfg_ready <= 1'b1;
                        busy      <= 1'b1;
                        lut_idx   <= '0;
                    end
                end
                RECV: begin
                    if (xfer && frame_full) begin
                        state     <= COMMIT;
                        cfg_ready <= 1'b0;
                    end
                end
                COMMIT: begin
                    if (lut_idx == LAST_LUT) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        state     <= RECV;
                        cfg_ready <= 1'b1;
                        lut_idx   <= lut_idx + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    cfg_ready <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lut_cfg_loader.sv
// Randomized scoreboard bench for lut_cfg_loader: a cycle-schedule model
// predicts commit/done events and handshake levels; a monitor checks them.
module tb_lut_cfg_loader;

    localparam int NL   = 4;
    localparam int WW   = 8;
    localparam int CFGW = 2 * (1 << 4) + 1;
    localparam int WPF  = (CFGW + WW - 1) / WW;
    localparam int LASTBITS = CFGW - WW * (WPF - 1);
    localparam int MAXC = 2048;

    typedef struct {
        int              cyc;
        logic [NL-1:0]   cen;
        logic            done;
        logic [CFGW-1:0] frame;
    } ev_t;

    logic            cclk = 1'b0;
    logic            reset;
    logic            start;
    logic            abort;
    logic [WW-1:0]   cfg_word;
    logic            cfg_valid;
    logic            cfg_ready;
    logic [CFGW-1:0] config_out;
    logic [NL-1:0]   cen;
    logic            busy;
    logic            done;

    lut_cfg_loader dut (
        .cclk       (cclk),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .cfg_word   (cfg_word),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .config_out (config_out),
        .cen        (cen),
        .busy       (busy),
        .done       (done)
    );

    always #5 cclk = ~cclk;

    int cyc = 0;
    always @(posedge cclk) cyc <= cyc + 1;

    bit          st_a [MAXC];
    bit          ab_a [MAXC];
    bit          rs_a [MAXC];
    bit          vl_a [MAXC];
    logic [7:0]  wd_a [MAXC];
    bit          exp_ready [MAXC];
    bit          exp_busy  [MAXC];
    bit          exp_zero  [MAXC];
    ev_t         q[$];

    int checks = 0;
    int errors = 0;
    int last_cyc = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h",
                     name, cyc, act, exp);
        end
    endtask

    // Model one full load. Start is sampled at cycle s; x is the cycle of
    // an abort/reset (or -1). Words are accepted on valid cycles while
    // receiving; each frame commits the cycle after its last word.
    task automatic load(input int s, input int vmode, input int wmode,
                        input int x, output int tend);
        int t;
        int n;
        bit halt;
        longint frame;
        logic [7:0] w;
        st_a[s] = 1'b1;
        for (int c = s + 1; c < s + 400 && c < MAXC; c++) begin
            if (vmode == 0)      vl_a[c] = 1'b1;
            else if (vmode == 1) vl_a[c] = ((c - s) % 2) == 1;
            else                 vl_a[c] = $urandom_range(0, 9) < 7;
        end
        t = s + 1;
        n = 0;
        halt = 0;
        for (int k = 0; k < NL && !halt; k++) begin
            frame = 0;
            for (int wi = 0; wi < WPF && !halt; wi++) begin
                while (1) begin
                    exp_ready[t] = 1'b1;
                    exp_busy[t]  = 1'b1;
                    if (t == x) begin
                        halt = 1;
                        break;
                    end
                    if (vl_a[t]) break;
                    t++;
                end
                if (!halt) begin
                    if (wmode == 0) w = 8'($urandom);
                    else            w = 8'(n + 1);
                    if (wmode == 2 && k == 2 && wi == WPF - 1) w = 8'hFF;
                    wd_a[t] = w;
                    if (wi == WPF - 1)
                        frame |= longint'(w & 8'((1 << LASTBITS) - 1)) << (WW * wi);
                    else
                        frame |= longint'(w) << (WW * wi);
                    n++;
                    t++;
                end
            end
            if (!halt) begin
                exp_busy[t] = 1'b1;
                q.push_back('{t, NL'(1 << k), 1'b0, frame[CFGW-1:0]});
                if (t == x) halt = 1;
                else t++;
            end
        end
        if (!halt) begin
            exp_busy[t] = 1'b1;
            q.push_back('{t, '0, 1'b1, '0});
        end
        tend = t;
    endtask

    task automatic build();
        int t;
        int s;
        int e;
        for (int c = 0; c < MAXC; c++) wd_a[c] = 8'($urandom);
        rs_a[0] = 1; rs_a[1] = 1; rs_a[2] = 1;
        exp_zero[3] = 1;
        t = 5;
        // ordered words 0x01..0x14, continuous valid
        load(t, 0, 1, -1, e); t = e + 3;
        // same, slice 2 last word 0xFF
        load(t, 0, 2, -1, e); t = e + 3;
        // valid toggling 1,0,1,0
        load(t, 1, 0, -1, e); t = e + 3;
        // extra start during slice 1
        s = t;
        load(s, 0, 0, -1, e); st_a[s + 8] = 1; t = e + 3;
        // start and abort together in IDLE
        st_a[t] = 1; ab_a[t] = 1; t = t + 3;
        // abort during word 2 of slice 2, then reload
        s = t;
        load(s, 0, 0, s + 15, e); ab_a[s + 15] = 1; t = s + 18;
        load(t, 0, 0, -1, e); t = e + 3;
        // abort while slice 1 commits
        s = t;
        load(s, 0, 0, s + 12, e); ab_a[s + 12] = 1; t = s + 15;
        // reset during slice 3 receive, then reload
        s = t;
        load(s, 0, 0, s + 20, e); rs_a[s + 20] = 1; exp_zero[s + 21] = 1;
        t = s + 23;
        load(t, 0, 0, -1, e); t = e + 3;
        // random-valid loads
        for (int i = 0; i < 4; i++) begin
            load(t, 2, 0, -1, e); t = e + 2 + $urandom_range(0, 3);
        end
        last_cyc = t + 5;
    endtask

    task automatic apply(input int c);
        reset     = rs_a[c];
        start     = st_a[c];
        abort     = ab_a[c];
        cfg_valid = vl_a[c];
        cfg_word  = wd_a[c];
    endtask

    // Monitor: levels every cycle, events popped from the scoreboard
    always @(negedge cclk) begin
        if (cyc >= 1 && cyc < MAXC) begin
            chk("cfg_ready", 64'(cfg_ready), 64'(exp_ready[cyc]));
            chk("busy", 64'(busy), 64'(exp_busy[cyc]));
            if (exp_zero[cyc]) begin
                chk("config_out_after_reset", 64'(config_out), 64'd0);
                chk("cen_after_reset", 64'(cen), 64'd0);
                chk("done_after_reset", 64'(done), 64'd0);
            end
            while (q.size() > 0 && q[0].cyc < cyc) begin
                chk("missed_event_cycle", 64'(cyc), 64'(q[0].cyc));
                void'(q.pop_front());
            end
            if (cen !== '0 || done !== 1'b0) begin
                if (q.size() == 0) begin
                    chk("unexpected_cen_done", {59'd0, done, cen}, 64'd0);
                end else begin
                    ev_t ev;
                    ev = q.pop_front();
                    chk("event_cycle", 64'(cyc), 64'(ev.cyc));
                    chk("cen", 64'(cen), 64'(ev.cen));
                    chk("done", 64'(done), 64'(ev.done));
                    if (!ev.done)
                        chk("config_out", 64'(config_out), 64'(ev.frame));
                end
            end
        end
    end

    initial begin
        build();
        apply(0);
        for (int c = 1; c <= last_cyc; c++) begin
            @(negedge cclk);
            apply(c);
        end
        @(negedge cclk);
        @(negedge cclk);
        while (q.size() > 0) begin
            chk("event_never_seen", 64'(cyc), 64'(q[0].cyc));
            void'(q.pop_front());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
